// File: rtl/ising_energy_if.sv
// Control, J-chunk stream and result signals between the annealing controller,
// the J-memory read port and ising_energy_engine.
interface ising_energy_if #(
  parameter int VECTOR_SIZE = 256,
  parameter int J_WIDTH     = 4,
  parameter int LANES       = 4
);
  localparam int NUM_CHUNKS   = VECTOR_SIZE / LANES;
  localparam int IDX_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int ENERGY_WIDTH = J_WIDTH + 2 * $clog2(VECTOR_SIZE) + 1;

  logic                                 start;
  logic                                 abort;
  logic [VECTOR_SIZE-1:0]               sigma;
  logic [ENERGY_WIDTH-1:0]              energy_prev;
  logic                                 j_valid;
  logic                                 j_ready;
  logic [VECTOR_SIZE*LANES*J_WIDTH-1:0] j_chunk;
  logic [IDX_W-1:0]                     chunk_idx;
  logic                                 busy;
  logic                                 done;
  logic [ENERGY_WIDTH-1:0]              energy;
  logic                                 better;

  modport master (
    output start, abort, sigma, energy_prev, j_valid, j_chunk,
    input  j_ready, chunk_idx, busy, done, energy, better
  );

  modport slave (
    input  start, abort, sigma, energy_prev, j_valid, j_chunk,
    output j_ready, chunk_idx, busy, done, energy, better
  );
endinterface

// File: rtl/ising_energy_engine.sv
// Streaming evaluator of E = sigma^T * J * sigma: one chunk of LANES columns per
// handshake, pipelined chunk sums accumulated into a signed energy.
module ising_energy_engine #(
  parameter int VECTOR_SIZE = 256,
  parameter int J_WIDTH     = 4,
  parameter int LANES       = 4,
  parameter int PIPE_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ising_energy_if.slave bus
);
  localparam int NUM_CHUNKS   = VECTOR_SIZE / LANES;
  localparam int IDX_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int DOT_W        = J_WIDTH + $clog2(VECTOR_SIZE) + 1;
  localparam int ENERGY_WIDTH = J_WIDTH + 2 * $clog2(VECTOR_SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                          state_r;
  logic [VECTOR_SIZE-1:0]          sigma_r;
  logic signed [ENERGY_WIDTH-1:0]  eprev_r;
  logic signed [ENERGY_WIDTH-1:0]  acc_r;
  logic signed [ENERGY_WIDTH-1:0]  energy_r;
  logic [IDX_W-1:0]                chunk_idx_r;
  logic                            j_ready_r;
  logic                            busy_r;
  logic                            done_r;
  logic                            better_r;

  logic                            hs_s;
  logic                            start_ok_s;
  logic                            last_chunk_s;
  logic                            acc_vld_s;
  logic                            tags_empty_s;
  logic [LANES-1:0]                sigma_lane_s;
  logic signed [DOT_W-1:0]         dot_s;
  logic signed [ENERGY_WIDTH-1:0]  chunk_sum_s;
  logic signed [ENERGY_WIDTH-1:0]  acc_sum_s;

  // A chunk arriving together with abort is dropped.
  assign hs_s         = (state_r == RUN) && bus.j_valid && !bus.abort;
  assign start_ok_s   = (state_r == IDLE) && bus.start && !bus.abort;
  assign last_chunk_s = (chunk_idx_r == IDX_W'(NUM_CHUNKS - 1));
  assign sigma_lane_s = LANES'(sigma_r >> (chunk_idx_r * LANES));

  // Per-lane column dot products, each weighted by the spin of its own column.
  always_comb begin
    dot_s       = {DOT_W{1'b0}};
    chunk_sum_s = {ENERGY_WIDTH{1'b0}};
    for (int c = 0; c < LANES; c++) begin
      dot_s = {DOT_W{1'b0}};
      for (int r = 0; r < VECTOR_SIZE; r++) begin
        if (sigma_r[r]) begin
          dot_s = dot_s + DOT_W'($signed(bus.j_chunk[(r*LANES+c)*J_WIDTH +: J_WIDTH]));
        end else begin
          dot_s = dot_s - DOT_W'($signed(bus.j_chunk[(r*LANES+c)*J_WIDTH +: J_WIDTH]));
        end
      end
      if (sigma_lane_s[c]) begin
        chunk_sum_s = chunk_sum_s + ENERGY_WIDTH'(dot_s);
      end else begin
        chunk_sum_s = chunk_sum_s - ENERGY_WIDTH'(dot_s);
      end
    end
  end

  generate
    if (PIPE_DEPTH == 0) begin : g_nopipe
      assign acc_vld_s    = hs_s;
      assign acc_sum_s    = chunk_sum_s;
      assign tags_empty_s = 1'b1;
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0]          vld_r;
      logic signed [ENERGY_WIDTH-1:0] sum_r [PIPE_DEPTH];

      // Valid-tagged shift register between chunk acceptance and accumulation.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_r <= {PIPE_DEPTH{1'b0}};
          for (int i = 0; i < PIPE_DEPTH; i++) begin
            sum_r[i] <= {ENERGY_WIDTH{1'b0}};
          end
        end else if (bus.abort || start_ok_s) begin
          vld_r <= {PIPE_DEPTH{1'b0}};
        end else begin
          vld_r[0] <= hs_s;
          sum_r[0] <= chunk_sum_s;
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            vld_r[i] <= vld_r[i-1];
            sum_r[i] <= sum_r[i-1];
          end
        end
      end

      assign acc_vld_s    = vld_r[PIPE_DEPTH-1];
      assign acc_sum_s    = sum_r[PIPE_DEPTH-1];
      assign tags_empty_s = ~|vld_r;
    end
  endgenerate

  // Control FSM, accumulator and registered status/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sigma_r     <= {VECTOR_SIZE{1'b0}};
      eprev_r     <= {ENERGY_WIDTH{1'b0}};
      acc_r       <= {ENERGY_WIDTH{1'b0}};
      energy_r    <= {ENERGY_WIDTH{1'b0}};
      chunk_idx_r <= {IDX_W{1'b0}};
      j_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      better_r    <= 1'b0;
    end else if (bus.abort) begin
      state_r     <= IDLE;
      chunk_idx_r <= {IDX_W{1'b0}};
      j_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (acc_vld_s) begin
        acc_r <= acc_r + acc_sum_s;
      end
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r     <= RUN;
            sigma_r     <= bus.sigma;
            eprev_r     <= bus.energy_prev;
            acc_r       <= {ENERGY_WIDTH{1'b0}};
            chunk_idx_r <= {IDX_W{1'b0}};
            j_ready_r   <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        RUN: begin
          if (bus.j_valid) begin
            if (last_chunk_s) begin
              state_r     <= DRAIN;
              chunk_idx_r <= {IDX_W{1'b0}};
              j_ready_r   <= 1'b0;
            end else begin
              chunk_idx_r <= chunk_idx_r + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          // done is high for the last DRAIN cycle; busy drops one cycle later.
          if (done_r) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else if (tags_empty_s) begin
            done_r   <= 1'b1;
            energy_r <= acc_r;
            better_r <= (acc_r < eprev_r);
          end
        end
        default: begin
          state_r   <= IDLE;
          j_ready_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.j_ready   = j_ready_r;
  assign bus.chunk_idx = chunk_idx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.energy    = energy_r;
  assign bus.better    = better_r;
endmodule

// File: tb/tb_ising_energy_engine.sv
// Self-checking bench: PIPE_DEPTH=2 and PIPE_DEPTH=0 engines share stimulus and are
// checked against a direct sigma^T*J*sigma reference.
module tb_ising_energy_engine;
  localparam int VS   = 8;
  localparam int JW   = 4;
  localparam int LN   = 2;
  localparam int NCH  = VS / LN;
  localparam int EW   = JW + 2 * $clog2(VS) + 1;
  localparam int PD [2] = '{2, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [VS-1:0] sigma = '0;
  logic [EW-1:0] energy_prev = '0;
  logic j_valid = 1'b0;
  logic [VS*LN*JW-1:0] j_chunk = '0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int jm [VS][VS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ising_energy_if #(.VECTOR_SIZE(VS), .J_WIDTH(JW), .LANES(LN)) bus2 ();
  ising_energy_if #(.VECTOR_SIZE(VS), .J_WIDTH(JW), .LANES(LN)) bus0 ();

  assign bus2.start = start;        assign bus0.start = start;
  assign bus2.abort = abort;        assign bus0.abort = abort;
  assign bus2.sigma = sigma;        assign bus0.sigma = sigma;
  assign bus2.energy_prev = energy_prev;  assign bus0.energy_prev = energy_prev;
  assign bus2.j_valid = j_valid;    assign bus0.j_valid = j_valid;
  assign bus2.j_chunk = j_chunk;    assign bus0.j_chunk = j_chunk;

  ising_energy_engine #(.VECTOR_SIZE(VS), .J_WIDTH(JW), .LANES(LN), .PIPE_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  ising_energy_engine #(.VECTOR_SIZE(VS), .J_WIDTH(JW), .LANES(LN), .PIPE_DEPTH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int spin(input logic [VS-1:0] s, input int i);
    return s[i] ? 1 : -1;
  endfunction

  function automatic int model_energy(input logic [VS-1:0] s);
    int e = 0;
    for (int i = 0; i < VS; i++)
      for (int j = 0; j < VS; j++)
        e += spin(s, i) * jm[i][j] * spin(s, j);
    return e;
  endfunction

  task automatic fill_j(input int v, input bit rnd);
    for (int r = 0; r < VS; r++)
      for (int c = 0; c < VS; c++)
        jm[r][c] = rnd ? (int'($urandom_range(0, 15)) - 8) : v;
  endtask

  task automatic load_chunk(input int k);
    int kk = (k < NCH) ? k : 0;
    for (int r = 0; r < VS; r++)
      for (int c = 0; c < LN; c++)
        j_chunk[(r*LN+c)*JW +: JW] = JW'(jm[r][kk*LN+c]);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ready2"}, bus2.j_ready, 0);   check_eq({tag, "_ready0"}, bus0.j_ready, 0);
    check_eq({tag, "_busy2"}, bus2.busy, 0);       check_eq({tag, "_busy0"}, bus0.busy, 0);
    check_eq({tag, "_done2"}, bus2.done, 0);       check_eq({tag, "_done0"}, bus0.done, 0);
    check_eq({tag, "_better2"}, bus2.better, 0);   check_eq({tag, "_better0"}, bus0.better, 0);
    check_eq({tag, "_energy2"}, bus2.energy, 0);   check_eq({tag, "_energy0"}, bus0.energy, 0);
    check_eq({tag, "_idx2"}, bus2.chunk_idx, 0);   check_eq({tag, "_idx0"}, bus0.chunk_idx, 0);
  endtask

  // vmode: 0 = j_valid held high, 1 = toggling, 2 = random
  task automatic run_eval(input logic [VS-1:0] sig, input int ep, input int vmode,
                          input bit extra_start, input int abort_after, input bit rst_drain);
    int hs = 0;
    int last_h = -100;
    int e_exp;
    int ndone [2] = '{0, 0};
    int dcyc [2] = '{-100, -100};
    logic [EW-1:0] e_hold [2];
    bit hs_now;
    e_exp = model_energy(sig);
    e_hold[0] = bus2.energy;
    e_hold[1] = bus0.energy;
    @(negedge clk);
    sigma = sig; energy_prev = EW'(ep); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", {bus2.busy, bus0.busy}, 3);
    for (int t = 0; t < 300; t++) begin
      if (bus2.done) begin ndone[0]++; dcyc[0] = cyc; check_eq("busy_with_done2", bus2.busy, 1);
        check_eq("idx_wrap2", bus2.chunk_idx, 0); end
      if (bus0.done) begin ndone[1]++; dcyc[1] = cyc; check_eq("busy_with_done0", bus0.busy, 1);
        check_eq("idx_wrap0", bus0.chunk_idx, 0); end
      if (cyc == dcyc[0] + 1) begin check_eq("done_pulse2", bus2.done, 0); check_eq("busy_fall2", bus2.busy, 0); end
      if (cyc == dcyc[1] + 1) begin check_eq("done_pulse0", bus0.done, 0); check_eq("busy_fall0", bus0.busy, 0); end
      if (dcyc[0] >= 0 && dcyc[1] >= 0 && cyc > dcyc[0] && cyc > dcyc[1]) break;
      if (rst_drain && hs == NCH) begin
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_in_drain");
        @(negedge clk);
        rst_n = 1'b1; j_valid = 1'b0;
        return;
      end
      if (dcyc[1] < 0) check_eq("ready0", bus0.j_ready, hs < NCH);
      if (dcyc[0] < 0) check_eq("ready2", bus2.j_ready, hs < NCH);
      j_valid = (hs < NCH) && (vmode == 0 || (vmode == 1 && t % 2 == 0) ||
                               (vmode == 2 && $urandom_range(0, 1) == 1));
      load_chunk(hs);
      start = extra_start && (t == 3);
      if (abort_after >= 0 && hs == abort_after) begin
        abort = 1'b1; j_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; j_valid = 1'b0;
        check_eq("abort_busy", {bus2.busy, bus0.busy}, 0);
        check_eq("abort_ready", {bus2.j_ready, bus0.j_ready}, 0);
        check_eq("abort_idx", {bus2.chunk_idx, bus0.chunk_idx}, 0);
        check_eq("abort_hold2", $signed(bus2.energy), $signed(e_hold[0]));
        check_eq("abort_hold0", $signed(bus0.energy), $signed(e_hold[1]));
        repeat (6) begin
          check_eq("abort_no_done", {bus2.done, bus0.done}, 0);
          @(negedge clk);
        end
        return;
      end
      hs_now = j_valid && bus2.j_ready;
      if (hs_now) begin
        check_eq("chunk_idx2", bus2.chunk_idx, hs);
        check_eq("chunk_idx0", bus0.chunk_idx, hs);
        last_h = cyc + 1;
      end
      @(negedge clk);
      if (hs_now) hs++;
    end
    j_valid = 1'b0; start = 1'b0;
    check_eq("handshakes", hs, NCH);
    check_eq("done_count2", ndone[0], 1);
    check_eq("done_count0", ndone[1], 1);
    check_eq("done_latency2", dcyc[0] - last_h, PD[0] + 1);
    check_eq("done_latency0", dcyc[1] - last_h, PD[1] + 1);
    check_eq("energy2", $signed(bus2.energy), e_exp);
    check_eq("energy0", $signed(bus0.energy), e_exp);
    check_eq("better2", bus2.better, e_exp < ep);
    check_eq("better0", bus0.better, e_exp < ep);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    fill_j(1, 1'b0);   run_eval(8'hFF, 100, 0, 1'b0, -1, 1'b0);
    fill_j(1, 1'b0);   run_eval(8'h0F, 0, 0, 1'b0, -1, 1'b0);
    fill_j(-8, 1'b0);  run_eval(8'h00, 0, 0, 1'b0, -1, 1'b0);
    fill_j(1, 1'b0);   run_eval(8'hFF, 100, 1, 1'b1, -1, 1'b0);
    fill_j(1, 1'b0);   run_eval(8'hFF, 100, 0, 1'b0, 2, 1'b0);
    fill_j(-8, 1'b0);  run_eval(8'h00, 0, 0, 1'b0, -1, 1'b0);
    fill_j(1, 1'b0);   run_eval(8'hFF, 100, 0, 1'b0, -1, 1'b1);
    run_eval(8'hFF, 100, 0, 1'b0, -1, 1'b0);
    for (int n = 0; n < 12; n++) begin
      fill_j(0, 1'b1);
      run_eval(VS'($urandom), int'($urandom_range(0, 1200)) - 600, 2, 1'b0, -1, 1'b0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
